fp8_accum_seq: RTL

FP8_ACCUM_SEQ -- requirements
Module: fp8_accum_seq

---
 rtl/fp8_accum_seq.sv | 139 +++++++++++++
 1 files changed

// File: rtl/fp8_accum_seq.sv
// Sequential fp8 (E4M3) reducer: sums LEN operands streamed over a valid/ready
// handshake through one combinational fp8 adder, then presents the sum.

module fp8_e4m3_adder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] answer
);
    // E4M3: bias 7, no infinities, S.1111.111 is NaN, overflow saturates to +/-448.
    logic [7:0]  x, y;
    logic [3:0]  ex, ey, d, mx, my;
    logic [19:0] sh;
    logic [6:0]  bx, sy, n;
    logic [7:0]  r;
    logic [4:0]  e, m;
    logic        rnd;

    // NOTE: combinational logic uses blocking '=' and gives every variable a
    // default first, so each path assigns it and no latch is inferred.
    always_comb begin
        x      = (a[6:0] >= b[6:0]) ? a : b;
        y      = (a[6:0] >= b[6:0]) ? b : a;
        ex     = (x[6:3] == 4'h0) ? 4'h1 : x[6:3];
        ey     = (y[6:3] == 4'h0) ? 4'h1 : y[6:3];
        mx     = {|x[6:3], x[2:0]};
        my     = {|y[6:3], y[2:0]};
        d      = ex - ey;
        sh     = {my, 16'h0000} >> d;
        sy     = {sh[19:14], sh[13] | (|sh[12:0])};
        bx     = {mx, 3'b000};
        r      = (x[7] == y[7]) ? ({1'b0, bx} + {1'b0, sy}) : ({1'b0, bx} - {1'b0, sy});
        e      = {1'b0, ex};
        n      = r[6:0];
        answer = 8'h00;
        if (r[7]) begin
            n = {r[7:2], r[1] | r[0]};
            e = e + 5'd1;
        end
        for (int i = 0; i < 6; i++) begin
            if (!n[6] && e > 5'd1) begin
                n = n << 1;
                e = e - 5'd1;
            end
        end
        // Round to nearest, ties to even, on guard/round/sticky bits n[2:0].
        rnd = n[2] & (n[1] | n[0] | n[3]);
        m   = {1'b0, n[6:3]} + {4'h0, rnd};
        if (m[4]) begin
            m = m >> 1;
            e = e + 5'd1;
        end
        if (x[6:0] == 7'h7F || y[6:0] == 7'h7F)
            answer = 8'h7F;
        else if (r == 8'h00)
            answer = {x[7] & y[7], 7'h00};
        else if (e > 5'd15 || (e == 5'd15 && m[2:0] == 3'b111))
            answer = {x[7], 7'h7E};
        else
            answer = {x[7], (m[3] ? e[3:0] : 4'h0), m[2:0]};
    end
endmodule

module fp8_accum_seq #(
    parameter int LEN_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [7:0]       out_data,
    input  logic             out_ready,
    output logic             busy,
    output logic [LEN_W-1:0] count
);
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t           state, state_next;
    logic [7:0]       acc, sum;
    logic [LEN_W-1:0] cnt, len_q;
    logic             take, last;

    fp8_e4m3_adder u_add (
        .a      (acc),
        .b      (in_data),
        .answer (sum)
    );

    assign take = (state == ACC) && in_valid;
    assign last = (cnt == len_q - LEN_W'(1));

    // NOTE: reset is synchronous, so rst_n is only tested inside the clocked
    // block and it takes priority over every other branch; state uses '<='.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (len == '0) ? DONE : ACC;
            ACC:     if (take && last) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc   <= 8'h00;
            cnt   <= '0;
            len_q <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    len_q <= len;
                    cnt   <= '0;
                    acc   <= 8'h00;
                end
                ACC: if (take) begin
                    // First operand bypasses the adder so no zero is ever added in.
                    acc <= (cnt == '0) ? in_data : sum;
                    cnt <= cnt + LEN_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == ACC);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_data  = acc;
    assign count     = cnt;
endmodule
